// File: rtl/k12a_lcd_pkg.sv
// Shared types and constants for the K12A character-LCD write sequencer:
// FSM state encoding, default bus timing and the slow clear/home opcodes.
package k12a_lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  localparam int DEF_SETUP_CYCLES     = 2;
  localparam int DEF_PULSE_CYCLES     = 4;
  localparam int DEF_HOLD_CYCLES      = 2;
  localparam int DEF_EXEC_CYCLES      = 40;
  localparam int DEF_LONG_EXEC_CYCLES = 1600;
  localparam int DEF_FIFO_DEPTH       = 4;

  localparam logic [7:0] OP_CLEAR     = 8'h01;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_HOME_ALT  = 8'h03;

  // Clear/home instructions need the controller's long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
  endfunction

endpackage

// File: rtl/k12a_sync_fifo.sv
// Single-clock FIFO with registered occupancy; pushes when full and pops when
// empty are ignored. DEPTH must be a power of two, at least 2.
module k12a_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/k12a_lcd_sequencer.sv
// Queues LCD instruction/data bytes and plays each one out as a timed
// RS/DATA setup, EN pulse, hold and controller-execution wait.
module k12a_lcd_sequencer
  import k12a_lcd_pkg::*;
#(
  parameter int SETUP_CYCLES     = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES     = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES      = DEF_HOLD_CYCLES,
  parameter int EXEC_CYCLES      = DEF_EXEC_CYCLES,
  parameter int LONG_EXEC_CYCLES = DEF_LONG_EXEC_CYCLES,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             cpu_clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_rs,
  input  logic [7:0]       cmd_data,
  output logic             cmd_ready,
  output logic             busy,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  input  logic             overflow_clear,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_en,
  output logic [7:0]       lcd_data
);

  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] EXEC_LD  = 16'(EXEC_CYCLES - 1);
  localparam logic [15:0] LONG_LD  = 16'(LONG_EXEC_CYCLES - 1);

  lcd_state_t  state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        en_nxt;
  logic        pop;
  logic        load_cmd;
  logic        long_cmd;
  logic        fifo_full;
  logic        fifo_empty;
  logic [8:0]  head;
  logic        dropped;

  k12a_sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (cpu_clock),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_rs, cmd_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign cmd_ready = !fifo_full;
  assign dropped   = cmd_valid && !cmd_ready;
  assign busy      = (state != ST_IDLE) || (level != '0);
  assign lcd_rw    = 1'b0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_nxt    = 1'b0;
    pop       = 1'b0;
    load_cmd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load_cmd  = 1'b1;
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = PULSE_LD;
          en_nxt    = 1'b1;
        end else begin
          cnt_nxt   = cnt - 16'd1;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt   = cnt - 16'd1;
          en_nxt    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = long_cmd ? LONG_LD : EXEC_LD;
        end else begin
          cnt_nxt   = cnt - 16'd1;
        end
      end
      ST_WAIT: begin
        // Chain straight into the next command so no IDLE cycle is spent.
        if (cnt == '0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            load_cmd  = 1'b1;
            state_nxt = ST_SETUP;
            cnt_nxt   = SETUP_LD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt   = cnt - 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      long_cmd <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      lcd_en <= en_nxt;
      if (load_cmd) begin
        lcd_rs   <= head[8];
        lcd_data <= head[7:0];
        long_cmd <= is_long_cmd(head[8], head[7:0]);
      end
      // A dropped push outranks a clear in the same cycle.
      if (dropped)             overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

endmodule
